clk_div_rst_gen: RTL and testbench
==================================

Name: clk_div_rst_gen

Overview:
- Parametrised multi-domain clock/reset generator; successor to the single-domain SoC clock/reset block.
- Derives NUM_CH divided clocks from one reference clock, each with a runtime-programmable integer divisor.
- Releases one synchronised reset per domain, staggered per channel and aligned to that domain's clock edge.
- Divisors are programmed over a req/ack config port; sits between the pad/FLL clock and the SoC/peripheral domains.

Parameters:
- NUM_CH, 4, number of output clock/reset domains (1..16).
- DIV_W, 8, divisor register width.
- DIV_DEFAULT, 2, divisor loaded into every channel at reset (>=2).
- RST_DLY, 8, base reset-release delay in clk_i cycles; channel k is released after RST_DLY*(k+1) cycles.

Ports:
- clk_i  in  1  reference clock.
- rstn_i  in  1  asynchronous active-low reset.
- testmode_i  in  1  1 = bypass: every clk_o equals clk_i and every rstn_o equals rstn_i.
- cfg_req_i  in  1  config request; held high until ack.
- cfg_wrn_i  in  1  0 = write, 1 = read.
- cfg_add_i  in  max(1,$clog2(NUM_CH))  channel index.
- cfg_data_i  in  DIV_W  divisor write data.
- cfg_ack_o  out  1  single-cycle acknowledge.
- cfg_r_data_o  out  DIV_W  read data, valid while cfg_ack_o is high.
- clk_o  out  NUM_CH  divided clocks.
- rstn_o  out  NUM_CH  per-domain resets.
- rst_done_o  out  1  all domains out of reset.

Behaviour:
- Reset values: clk_o=0, rstn_o=0, cfg_ack_o=0, cfg_r_data_o=0, rst_done_o=0, counters=0, divisors=DIV_DEFAULT.
- rstn_i assertion clears all flops asynchronously; every rstn_o drops immediately, regardless of clock.
- Release: rstn_i goes through a 2-flop synchroniser on clk_i, giving rst_sync.
- After rst_sync rises, a shared sequence counter starts and the channel counters start running.
- rstn_o[k] rises on the first clk_i edge at which seq_cnt >= RST_DLY*(k+1) and channel k's counter wraps to 0, i.e. on a rising edge of clk_o[k].
- Once released, rstn_o[k] stays high until the next rstn_i assertion.
- rst_done_o rises one cycle after the last rstn_o rises.
- Divider, per channel with divisor D:
  - cnt counts 0..D-1 and wraps.
  - clk_o[k] is a registered output: high when cnt < D>>1, else low.
  - Period is D cycles: high floor(D/2), low ceil(D/2).
- Divisor write:
  - Written values below 2 saturate to 2; values above 2^DIV_W-1 cannot be represented.
  - The value goes to pending[k] and takes effect at the next wrap of cnt, so no period is ever truncated or glitched.
  - A second write before the wrap overwrites pending[k].
- Config handshake:
  - On cfg_req_i=1 with cfg_ack_o=0, perform the access and raise cfg_ack_o for exactly one cycle on the next edge.
  - The master drops cfg_req_i after seeing ack; no new ack is issued while cfg_req_i remains high in the same cycle.
  - Reads return pending[k], i.e. the most recently written saturated value; cfg_r_data_o holds its last value otherwise.
  - cfg_add_i >= NUM_CH: writes are ignored, reads return 0, and ack is still given.
  - The config port is functional during the reset sequence, before rst_done_o.
- testmode_i=1 forces clk_o[k]=clk_i through the glitch-free mux and rstn_o[k]=rstn_i combinationally. Internal state keeps running.
- Reset mid-operation: a pending divisor is discarded and all channels return to DIV_DEFAULT.

Decomposition:
- Package clk_rst_pkg holds:
  - the DIV_W default and DIV_MIN=2 constant;
  - the cfg access enum {CFG_WRITE=0, CFG_READ=1};
  - a function computing the release threshold RST_DLY*(k+1).
- Sub-module clk_div_ch holds one channel: cnt, divisor, pending, registered clock, and per-channel release flop.
- The top module instantiates NUM_CH clk_div_ch plus the synchroniser, the sequence counter, and the config decoder.
- The existing cluster_clock_mux2 is reused per channel for testmode bypass.

Test Plan:
- Release sequence (NUM_CH=4, RST_DLY=8, all D=2): release rstn_i → rstn_o[0..3] rise at approximately cycles 2+8, 2+16, 2+24, 2+32, each on a clk_o rising edge; rst_done_o rises one cycle after rstn_o[3].
- Divisor change: write ch1 D=5 mid-period → the current period completes at D=2, then clk_o[1] runs high 2 / low 3 with no runt pulse; read ch1 returns 5.
- Saturation and bad address: write D=0 to ch2 → reads back 2 and ch2 period = 2. Write to address 7 → ignored, ack given; read from address 7 returns 0.
- Back-to-back writes: write ch0 D=6, then D=9 before the wrap → only 9 takes effect; no period of 6 is observed.
- Async reset mid-run: assert rstn_i between clk_i edges → all rstn_o fall with no clock; divisors return to 2; the release sequence repeats.
- Testmode: testmode_i=1 → clk_o == clk_i on every channel and rstn_o follows rstn_i combinationally.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared constants, config access encoding and release-threshold helper
// for the multi-domain clock/reset generator.
// Imported by clk_div_ch and clk_div_rst_gen.
package clk_rst_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int DIV_MIN   = 2;

    typedef enum logic {
        CFG_WRITE = 1'b0,
        CFG_READ  = 1'b1
    } cfg_acc_e;

    // clk_i cycles after synchronised reset release before domain ch may leave reset
    function automatic int unsigned rel_thresh(input int unsigned dly, input int unsigned ch);
        return dly * (ch + 1);
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: wrap counter, active/pending divisor, registered clock, release flop.
// Latency: clock output registered; a new divisor applies at the next counter wrap.
// Backpressure: none; writes land in the pending register unconditionally.
module clk_div_ch
    import clk_rst_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DIV_DEFAULT = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_run,
    input  logic             i_rel_ok,
    input  logic             i_wr_en,
    input  logic [DIV_W-1:0] i_wr_div,
    output logic             o_clk,
    output logic             o_rstn,
    output logic [DIV_W-1:0] o_pending
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pend;
    logic             r_clk;
    logic             r_rstn;
    logic             w_wrap;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_div_nxt;

    // Wrap detection; the pending divisor is only adopted on a wrap so no period is cut short
    always_comb begin
        w_wrap    = (r_cnt == (r_div - DIV_W'(1)));
        w_cnt_nxt = w_wrap ? '0 : (r_cnt + DIV_W'(1));
        w_div_nxt = w_wrap ? r_pend : r_div;
    end

    // Counter, active divisor and registered clock (high for the first floor(D/2) counts)
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt <= '0;
            r_div <= DIV_RST;
            r_clk <= 1'b0;
        end else if (i_run) begin
            r_cnt <= w_cnt_nxt;
            r_div <= w_div_nxt;
            r_clk <= (w_cnt_nxt < (w_div_nxt >> 1));
        end
    end

    // Pending divisor; a later write before the wrap simply replaces an earlier one
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_pend <= DIV_RST;
        end else if (i_wr_en) begin
            r_pend <= i_wr_div;
        end
    end

    // Sticky release, taken on a wrap so the reset deasserts with a rising clk_o edge
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rstn <= 1'b0;
        end else if (i_run && i_rel_ok && w_wrap) begin
            r_rstn <= 1'b1;
        end
    end

    assign o_clk     = r_clk;
    assign o_rstn    = r_rstn;
    assign o_pending = r_pend;

endmodule

// File: rtl/cluster_clock_mux2.sv
// Two-input clock mux used for the testmode bypass of each divided clock.
// Latency: combinational.
// Backpressure: none; the select is expected to be static during operation.
module cluster_clock_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);

    // Behavioural model; in silicon this maps to the library glitch-free clock mux cell.
    assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/clk_div_rst_gen.sv
// Multi-domain clock/reset generator: NUM_CH programmable divided clocks with staggered resets.
// Latency: reset sync 2 cycles, channel k released after RST_DLY*(k+1) cycles on a clk_o rise; cfg ack 1 cycle.
// Backpressure: cfg master holds cfg_req_i until the single-cycle cfg_ack_o.
module clk_div_rst_gen
    import clk_rst_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DIV_DEFAULT = 2,
    parameter int RST_DLY     = 8
) (
    input  logic                                            clk_i,
    input  logic                                            rstn_i,
    input  logic                                            testmode_i,
    input  logic                                            cfg_req_i,
    input  logic                                            cfg_wrn_i,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  cfg_add_i,
    input  logic [DIV_W-1:0]                                cfg_data_i,
    output logic                                            cfg_ack_o,
    output logic [DIV_W-1:0]                                cfg_r_data_o,
    output logic [NUM_CH-1:0]                               clk_o,
    output logic [NUM_CH-1:0]                               rstn_o,
    output logic                                            rst_done_o
);

    localparam int AW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SEQ_MAX = int'(rel_thresh(RST_DLY, NUM_CH - 1));
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

    logic [1:0]        r_sync;
    logic [SEQ_W-1:0]  r_seq_cnt;
    logic              r_ack;
    logic [DIV_W-1:0]  r_rdata;
    logic              r_done;
    logic              w_run;
    logic              w_cfg_go;
    logic              w_is_wr;
    logic [DIV_W-1:0]  w_wr_div;
    logic [DIV_W-1:0]  w_rd_div;
    logic [NUM_CH-1:0] w_wr_en;
    logic [NUM_CH-1:0] w_clk_int;
    logic [NUM_CH-1:0] w_rstn_int;
    logic [DIV_W-1:0]  w_pend [NUM_CH];

    assign w_run    = r_sync[1];
    assign w_cfg_go = cfg_req_i & ~r_ack;
    assign w_is_wr  = (cfg_acc_e'(cfg_wrn_i) == CFG_WRITE);

    // Two-flop synchroniser: assertion is asynchronous, release is aligned to clk_i
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    // Shared release sequence counter, saturating once the last channel's threshold is reached
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_seq_cnt <= '0;
        end else if (w_run && (r_seq_cnt != SEQ_W'(SEQ_MAX))) begin
            r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
        end
    end

    // Config decode: saturate written divisors, address out of range writes nothing and reads 0
    always_comb begin
        w_wr_div = (cfg_data_i < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg_data_i;
        w_wr_en  = '0;
        w_rd_div = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cfg_add_i == AW'(k)) begin
                w_wr_en[k] = w_cfg_go & w_is_wr;
                w_rd_div   = w_pend[k];
            end
        end
    end

    // Single-cycle ack; read data is captured with the ack and held until the next read
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_cfg_go;
            if (w_cfg_go && !w_is_wr) begin
                r_rdata <= w_rd_div;
            end
        end
    end

    // All domains released; follows the last channel's release by one cycle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_done <= 1'b0;
        end else begin
            r_done <= &w_rstn_int;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic w_rel_ok;
        assign w_rel_ok = (r_seq_cnt >= SEQ_W'(rel_thresh(RST_DLY, k)));

        clk_div_ch #(
            .DIV_W       (DIV_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_ch (
            .i_clk     (clk_i),
            .i_rstn    (rstn_i),
            .i_run     (w_run),
            .i_rel_ok  (w_rel_ok),
            .i_wr_en   (w_wr_en[k]),
            .i_wr_div  (w_wr_div),
            .o_clk     (w_clk_int[k]),
            .o_rstn    (w_rstn_int[k]),
            .o_pending (w_pend[k])
        );

        cluster_clock_mux2 u_clk_mux (
            .clk0_i    (w_clk_int[k]),
            .clk1_i    (clk_i),
            .clk_sel_i (testmode_i),
            .clk_o     (clk_o[k])
        );

        assign rstn_o[k] = testmode_i ? rstn_i : w_rstn_int[k];
    end

    assign cfg_ack_o    = r_ack;
    assign cfg_r_data_o = r_rdata;
    assign rst_done_o   = r_done;

endmodule

// File: tb/tb_clk_div_rst_gen.sv
// Directed bench for clk_div_rst_gen: a 4-channel instance for timing/divider checks and a
// 5-channel instance so that unmapped config addresses (5..7) can be exercised.
// Inputs change at negedge (or between edges); outputs are sampled at negedge or #1 after posedge.
module tb_clk_div_rst_gen;

    logic       clk;
    logic       rstn;
    logic       testmode;

    logic       req4, wrn4, ack4, done4;
    logic [1:0] add4;
    logic [7:0] data4, rd4;
    logic [3:0] clko4, rstno4;

    logic       req5, wrn5, ack5, done5;
    logic [2:0] add5;
    logic [7:0] data5, rd5;
    logic [4:0] clko5, rstno5;

    int n_tests = 0;
    int n_fail  = 0;

    // Release edges counted in clk_i rising edges after rstn_i release:
    // 2 sync edges, seq_cnt reaches T at edge T+2 and is seen at edge T+3, then the next
    // D=2 wrap (even edge) -> T+4 for T = 8, 16, 24, 32. rst_done one edge after the last.
    int exp_edge [4] = '{12, 20, 28, 36};

    typedef struct {
        bit         sel5;
        bit         wrn;
        logic [2:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
    } cfg_vec_t;

    cfg_vec_t vecs [15];

    clk_div_rst_gen #(.NUM_CH(4), .DIV_W(8), .DIV_DEFAULT(2), .RST_DLY(8)) u_dut (
        .clk_i(clk), .rstn_i(rstn), .testmode_i(testmode),
        .cfg_req_i(req4), .cfg_wrn_i(wrn4), .cfg_add_i(add4), .cfg_data_i(data4),
        .cfg_ack_o(ack4), .cfg_r_data_o(rd4),
        .clk_o(clko4), .rstn_o(rstno4), .rst_done_o(done4)
    );

    clk_div_rst_gen #(.NUM_CH(5), .DIV_W(8), .DIV_DEFAULT(2), .RST_DLY(8)) u_dut5 (
        .clk_i(clk), .rstn_i(rstn), .testmode_i(testmode),
        .cfg_req_i(req5), .cfg_wrn_i(wrn5), .cfg_add_i(add5), .cfg_data_i(data5),
        .cfg_ack_o(ack5), .cfg_r_data_o(rd5),
        .clk_o(clko5), .rstn_o(rstno5), .rst_done_o(done5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One config access; called at a negedge, returns at a negedge one cycle after the ack
    task automatic cfg(input bit sel5, input bit wrn, input logic [2:0] addr, input logic [7:0] data,
                       output logic [7:0] rdata, output bit acked, output logic ack_next);
        if (sel5) begin
            req5 = 1'b1; wrn5 = wrn; add5 = addr; data5 = data;
        end else begin
            req4 = 1'b1; wrn4 = wrn; add4 = addr[1:0]; data4 = data;
        end
        acked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ((sel5 ? ack5 : ack4) === 1'b1) begin
                acked = 1'b1;
                break;
            end
        end
        rdata = sel5 ? rd5 : rd4;
        req4 = 1'b0;
        req5 = 1'b0;
        @(negedge clk);
        ack_next = sel5 ? ack5 : ack4;
    endtask

    // Advance to the next sampled 0->1 of clko4[ch]; n = samples taken, -1 on timeout
    task automatic wait_rise(input int ch, output int n);
        logic prev;
        prev = clko4[ch];
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (!prev && clko4[ch]) return;
            prev = clko4[ch];
        end
        n = -1;
    endtask

    // Length of the run of samples equal to val, starting at the current sample
    task automatic run_len(input int ch, input logic val, output int n);
        n = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (clko4[ch] !== val) return;
            n++;
        end
    endtask

    task automatic measure(input string tag, input int ch, input int exp_hi, input int exp_lo);
        int n, hi, lo;
        wait_rise(ch, n);
        run_len(ch, 1'b1, hi);
        run_len(ch, 1'b0, lo);
        check($sformatf("%s high", tag), hi, exp_hi);
        check($sformatf("%s low", tag), lo, exp_lo);
    endtask

    // Release rstn_i at a negedge and record the edge at which each output first rises
    task automatic do_release(input string tag);
        int          e [4];
        int          de;
        logic [3:0]  hi;
        e  = '{default: 0};
        de = 0;
        hi = '0;
        rstn = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (rstno4[k] && e[k] == 0) begin
                    e[k]  = n;
                    hi[k] = clko4[k];
                end
            end
            if (done4 && de == 0) de = n;
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s rstn_o[%0d] edge", tag, k), e[k], exp_edge[k]);
            check($sformatf("%s clk_o[%0d] high at release", tag, k), hi[k], 1);
        end
        check($sformatf("%s rst_done edge", tag), de, 37);
        check($sformatf("%s rstn_o held", tag), rstno4, 4'hf);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  rd;
        bit          acked;
        logic        ackn;
        int          n, hi, lo;
        logic [15:0] samp;

        // {sel5, wrn, addr, data, expected cfg_r_data_o at ack}; writes expect the held value
        vecs[0]  = '{1'b0, 1'b1, 3'd0, 8'd0,   8'd2};
        vecs[1]  = '{1'b0, 1'b0, 3'd2, 8'd0,   8'd2};
        vecs[2]  = '{1'b0, 1'b1, 3'd2, 8'd0,   8'd2};
        vecs[3]  = '{1'b0, 1'b0, 3'd3, 8'd1,   8'd2};
        vecs[4]  = '{1'b0, 1'b1, 3'd3, 8'd0,   8'd2};
        vecs[5]  = '{1'b0, 1'b0, 3'd3, 8'd3,   8'd2};
        vecs[6]  = '{1'b0, 1'b1, 3'd3, 8'd0,   8'd3};
        vecs[7]  = '{1'b1, 1'b0, 3'd7, 8'd9,   8'd0};
        vecs[8]  = '{1'b1, 1'b1, 3'd7, 8'd0,   8'd0};
        vecs[9]  = '{1'b1, 1'b1, 3'd4, 8'd0,   8'd2};
        vecs[10] = '{1'b1, 1'b0, 3'd4, 8'd255, 8'd2};
        vecs[11] = '{1'b1, 1'b1, 3'd4, 8'd0,   8'd255};
        vecs[12] = '{1'b1, 1'b0, 3'd4, 8'd1,   8'd255};
        vecs[13] = '{1'b1, 1'b1, 3'd4, 8'd0,   8'd2};
        vecs[14] = '{1'b1, 1'b1, 3'd5, 8'd0,   8'd0};

        rstn = 1'b0; testmode = 1'b0;
        req4 = 1'b0; wrn4 = 1'b0; add4 = '0; data4 = '0;
        req5 = 1'b0; wrn5 = 1'b0; add5 = '0; data5 = '0;
        repeat (3) @(negedge clk);

        check("reset rstn_o", rstno4, 4'h0);
        check("reset clk_o", clko4, 4'h0);
        check("reset ack", ack4, 1'b0);
        check("reset rdata", rd4, 8'h00);
        check("reset rst_done", done4, 1'b0);

        do_release("rel1");
        check("dut5 rst_done", done5, 1'b1);
        check("dut5 rstn_o", rstno5, 5'h1f);

        for (int i = 0; i < 15; i++) begin
            cfg(vecs[i].sel5, vecs[i].wrn, vecs[i].addr, vecs[i].data, rd, acked, ackn);
            check($sformatf("vec%0d ack", i), acked, 1'b1);
            check($sformatf("vec%0d ack single", i), ackn, 1'b0);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
        end

        measure("ch2 D=2 (sat)", 2, 1, 1);
        measure("ch3 D=3", 3, 1, 2);

        // Write ch1 D=5 right after a clk_o[1] rise: one more D=2 period, then 2 high / 3 low
        wait_rise(1, n);
        check("ch1 rise found", (n > 0), 1'b1);
        req4 = 1'b1; wrn4 = 1'b0; add4 = 2'd1; data4 = 8'd5;
        samp = '0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            samp[i-1] = clko4[1];
            if (i == 1) begin
                check("ch1 write ack", ack4, 1'b1);
                req4 = 1'b0;
            end
        end
        check("ch1 waveform after D=5 write", samp, 16'h18c6);
        cfg(1'b0, 1'b1, 3'd1, 8'd0, rd, acked, ackn);
        check("ch1 read back", rd, 8'd5);

        // ch0 to D=20, then 6 and 9 inside one 20-cycle period: only 9 may appear
        cfg(1'b0, 1'b0, 3'd0, 8'd20, rd, acked, ackn);
        wait_rise(0, n);
        cfg(1'b0, 1'b0, 3'd0, 8'd6, rd, acked, ackn);
        check("ch0 write 6 ack", acked, 1'b1);
        cfg(1'b0, 1'b0, 3'd0, 8'd9, rd, acked, ackn);
        check("ch0 write 9 ack", acked, 1'b1);
        wait_rise(0, n);
        check("ch0 D=20 period untruncated", n, 16);
        run_len(0, 1'b1, hi);
        run_len(0, 1'b0, lo);
        check("ch0 D=9 high", hi, 4);
        check("ch0 D=9 low", lo, 5);
        run_len(0, 1'b1, hi);
        check("ch0 D=9 second high", hi, 4);
        cfg(1'b0, 1'b1, 3'd0, 8'd0, rd, acked, ackn);
        check("ch0 read back", rd, 8'd9);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("async rst rstn_o", rstno4, 4'h0);
        check("async rst clk_o", clko4, 4'h0);
        check("async rst rst_done", done4, 1'b0);
        check("async rst rdata", rd4, 8'h00);
        @(negedge clk);
        do_release("rel2");
        cfg(1'b0, 1'b1, 3'd0, 8'd0, rd, acked, ackn);
        check("ch0 default after reset", rd, 8'd2);
        cfg(1'b0, 1'b1, 3'd1, 8'd0, rd, acked, ackn);
        check("ch1 default after reset", rd, 8'd2);
        measure("ch0 after reset", 0, 1, 1);

        // Testmode bypass
        testmode = 1'b1;
        #1;
        check("tm clk_o low", clko4, {4{clk}});
        check("tm rstn_o", rstno4, 4'hf);
        @(posedge clk);
        #1;
        check("tm clk_o high", clko4, {4{clk}});
        check("tm dut5 clk_o", clko5, {5{clk}});
        #1 rstn = 1'b0;
        #1;
        check("tm rstn_o follows low", rstno4, 4'h0);
        check("tm clk_o in reset", clko4, {4{clk}});
        rstn = 1'b1;
        #1;
        check("tm rstn_o follows high", rstno4, 4'hf);
        check("tm dut5 rstn_o", rstno5, 5'h1f);
        @(negedge clk);
        testmode = 1'b0;
        #1;
        check("tm off internal rstn_o", rstno4, 4'h0);
        check("tm off internal clk_o", clko4, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
